// File: rtl/percept_pkg.sv
// Shared types and constants for the perceptron sequencer.
//   DEF_WORD_W    default width of input/weight/result words
//   DEF_SHIFT_LEN default length of percept's operand shift chain
//   state_t       sequencer FSM states
//   serdes_ctl_t  per-cycle strobes from the FSM to the serialiser
package percept_pkg;

    localparam int DEF_WORD_W    = 32;
    localparam int DEF_SHIFT_LEN = 2 * DEF_WORD_W;

    typedef enum logic [2:0] {
        IDLE,
        ACCEPT,
        SHIFT,
        MAC,
        DRAIN,
        DONE
    } state_t;

    typedef struct packed {
        logic load;     // take a new {weight,input} pair
        logic shift;    // advance the operand PISO one bit
        logic capture;  // take one result bit from percept
    } serdes_ctl_t;

endpackage

// File: rtl/percept_serdes.sv
// Bit-level datapath between the word interface and percept.
//   clk, nRst         clock, async active-low reset
//   ctl               load/shift/capture strobes from the FSM
//   in_data/in_weight operand words, sampled on ctl.load
//   ser_out           registered serial operand bit (to percept.data_in)
//   ser_in            serial result bit (from percept.data_out)
//   res_data          result word assembled MSB first
module percept_serdes
    import percept_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W
) (
    input  logic              clk,
    input  logic              nRst,
    input  serdes_ctl_t       ctl,
    input  logic [WORD_W-1:0] in_data,
    input  logic [WORD_W-1:0] in_weight,
    output logic              ser_out,
    input  logic              ser_in,
    output logic [WORD_W-1:0] res_data
);

    localparam int SL = 2 * WORD_W;

    logic [SL-1:0] piso;

    // The weight MSB goes straight to ser_out on load so the first bit is
    // on the wire in the same cycle p_shift_in rises; the PISO then holds the
    // remaining 2*WORD_W-1 bits left-aligned.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            piso     <= '0;
            ser_out  <= 1'b0;
            res_data <= '0;
        end else begin
            if (ctl.load) begin
                ser_out <= in_weight[WORD_W-1];
                piso    <= {in_weight[WORD_W-2:0], in_data, 1'b0};
            end else if (ctl.shift) begin
                ser_out <= piso[SL-1];
                piso    <= {piso[SL-2:0], 1'b0};
            end else begin
                ser_out <= 1'b0;
            end
            // First captured bit walks up to the MSB after WORD_W captures.
            if (ctl.capture)
                res_data <= {res_data[WORD_W-2:0], ser_in};
        end
    end

endmodule

// File: rtl/percept_seq.sv
// Sequencer driving one serial perceptron (percept) from a parallel stream
// of (input, weight) pairs; returns the accumulated result as a word.
//   clk, nRst                 clock, async active-low reset
//   start, n_terms, busy      job request / term count / job in flight
//   in_valid/in_ready         term pair handshake (in_data, in_weight)
//   res_valid/res_ready       result handshake (res_data)
//   p_shift_in, p_shift_out,
//   p_mac, p_data_in          control/data to percept
//   p_data_out                serial result from percept
module percept_seq
    import percept_pkg::*;
#(
    parameter int WORD_W  = DEF_WORD_W,
    parameter int MAC_CYC = 1,
    parameter int NT_W    = 8
) (
    input  logic              clk,
    input  logic              nRst,
    input  logic              start,
    input  logic [NT_W-1:0]   n_terms,
    output logic              busy,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    input  logic [WORD_W-1:0] in_weight,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [WORD_W-1:0] res_data,
    output logic              p_shift_in,
    output logic              p_shift_out,
    output logic              p_mac,
    output logic              p_data_in,
    input  logic              p_data_out
);

    localparam int SL   = 2 * WORD_W;
    localparam int BC_W = $clog2(SL);

    state_t            state;
    logic [BC_W-1:0]   bit_cnt;
    logic [2:0]        mac_cnt;
    logic [NT_W-1:0]   term_cnt;
    logic [NT_W-1:0]   n_cap;
    logic [NT_W-1:0]   term_nxt;
    serdes_ctl_t       ctl;

    assign term_nxt = term_cnt + 1'b1;

    // The last SHIFT cycle does not advance the PISO, so p_data_in falls
    // back to 0 together with p_shift_in. Capture tracks p_shift_out itself,
    // which is exactly the set of edges percept presents a result bit on.
    always_comb begin
        ctl         = '0;
        ctl.load    = (state == ACCEPT) && in_valid && in_ready;
        ctl.shift   = (state == SHIFT) && (bit_cnt != BC_W'(SL - 1));
        ctl.capture = p_shift_out;
    end

    percept_serdes #(.WORD_W(WORD_W)) u_serdes (
        .clk      (clk),
        .nRst     (nRst),
        .ctl      (ctl),
        .in_data  (in_data),
        .in_weight(in_weight),
        .ser_out  (p_data_in),
        .ser_in   (p_data_out),
        .res_data (res_data)
    );

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            mac_cnt     <= '0;
            term_cnt    <= '0;
            n_cap       <= '0;
            busy        <= 1'b0;
            in_ready    <= 1'b0;
            res_valid   <= 1'b0;
            p_shift_in  <= 1'b0;
            p_shift_out <= 1'b0;
            p_mac       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && n_terms != '0) begin
                        n_cap    <= n_terms;
                        term_cnt <= '0;
                        busy     <= 1'b1;
                        in_ready <= 1'b1;
                        state    <= ACCEPT;
                    end
                end
                ACCEPT: begin
                    if (in_valid) begin
                        in_ready   <= 1'b0;
                        p_shift_in <= 1'b1;
                        bit_cnt    <= '0;
                        state      <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Go straight into MAC so percept sees no gap.
                    if (bit_cnt == BC_W'(SL - 1)) begin
                        p_shift_in <= 1'b0;
                        p_mac      <= 1'b1;
                        mac_cnt    <= '0;
                        state      <= MAC;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                MAC: begin
                    if (mac_cnt == 3'(MAC_CYC - 1)) begin
                        p_mac    <= 1'b0;
                        term_cnt <= term_nxt;
                        if (term_nxt == n_cap) begin
                            p_shift_out <= 1'b1;
                            bit_cnt     <= '0;
                            state       <= DRAIN;
                        end else begin
                            in_ready <= 1'b1;
                            state    <= ACCEPT;
                        end
                    end else begin
                        mac_cnt <= mac_cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    // Draining also empties percept's accumulator for the next job.
                    if (bit_cnt == BC_W'(WORD_W - 1)) begin
                        p_shift_out <= 1'b0;
                        res_valid   <= 1'b1;
                        state       <= DONE;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_percept_seq.sv
// Self-checking bench for percept_seq with a behavioural percept model.
module tb_percept_seq;

    localparam int W  = 32;
    localparam int NT = 8;

    logic          clk = 1'b0;
    logic          nRst = 1'b0;
    logic          start = 1'b0;
    logic [NT-1:0] n_terms = '0;
    logic          busy;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic [W-1:0]  in_weight = '0;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [W-1:0]  res_data;
    logic          p_shift_in, p_shift_out, p_mac, p_data_in, p_data_out;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    percept_seq #(.WORD_W(W), .MAC_CYC(1), .NT_W(NT)) dut (
        .clk(clk), .nRst(nRst), .start(start), .n_terms(n_terms), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_weight(in_weight),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .p_shift_in(p_shift_in), .p_shift_out(p_shift_out), .p_mac(p_mac),
        .p_data_in(p_data_in), .p_data_out(p_data_out)
    );

    // Behavioural percept: 64-bit operand chain {weight,input}, signed MAC,
    // result shifted out MSB first (which also clears the accumulator).
    logic [2*W-1:0]        psr;
    logic [W-1:0]          acc;
    logic                  mac_q;
    logic signed [2*W-1:0] prod;
    assign prod       = $signed(psr[2*W-1:W]) * $signed(psr[W-1:0]);
    assign p_data_out = acc[W-1];

    always @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            psr <= '0; acc <= '0; mac_q <= 1'b0;
        end else begin
            mac_q <= p_mac;
            if (p_shift_in) psr <= {psr[2*W-2:0], p_data_in};
            if (p_mac && !mac_q) acc <= acc + prod[W-1:0];
            else if (p_shift_out) acc <= {acc[W-2:0], 1'b0};
        end
    end

    assert property (@(posedge clk) disable iff (!nRst) $onehot0({p_shift_in, p_mac, p_shift_out}));

    typedef struct {
        int              n;
        logic [2:0][W-1:0] d;
        logic [2:0][W-1:0] w;
        logic [W-1:0]    exp;
        int              gap;    // idle cycles before term 2
        int              hold;   // cycles res_ready is held low
        bit              poke;   // pulse start in the middle of SHIFT
    } vec_t;

    function automatic vec_t mk(int n, logic [W-1:0] d0, logic [W-1:0] w0,
                                logic [W-1:0] d1, logic [W-1:0] w1,
                                logic [W-1:0] d2, logic [W-1:0] w2,
                                logic [W-1:0] exp, int gap, int hold, bit poke);
        vec_t v;
        v.n = n; v.d[0] = d0; v.w[0] = w0; v.d[1] = d1; v.w[1] = w1;
        v.d[2] = d2; v.w[2] = w2; v.exp = exp; v.gap = gap; v.hold = hold; v.poke = poke;
        return v;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic pulse_start(logic [NT-1:0] n);
        start = 1'b1; n_terms = n;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Returns at the 66th negedge after the handshake edge.
    task automatic do_term(logic [W-1:0] d, logic [W-1:0] w, bit last, bit poke);
        logic [2*W-1:0] stream = '0;
        int sin = 0, mac = 0, rdy_hi = 0, oh = 0, n = 0;
        bit mac65 = 1'b0;
        in_data = d; in_weight = w; in_valid = 1'b1;
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        if (!in_ready) begin
            chk("in_ready_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1 in_valid = 1'b0;
        for (int k = 1; k <= 65; k++) begin
            @(negedge clk);
            if (p_shift_in) begin stream = {stream[2*W-2:0], p_data_in}; sin++; end
            if (p_mac) mac++;
            if (k == 65) mac65 = p_mac;
            if (in_ready) rdy_hi++;
            if (32'(p_shift_in) + 32'(p_mac) + 32'(p_shift_out) > 1) oh++;
            if (poke && k == 10) begin start = 1'b1; n_terms = 8'd5; end
            if (poke && k == 11) start = 1'b0;
        end
        chk("shift_stream", stream, {w, d});
        chk("shift_len", sin, 64);
        chk("mac_len", mac, 1);
        chk("mac_after_shift", mac65, 1);
        chk("in_ready_low", rdy_hi, 0);
        chk("onehot", oh, 0);
        @(negedge clk);
        if (last) chk("drain_start", p_shift_out, 1);
        else      chk("next_ready_latency", in_ready, 1);
    endtask

    task automatic run_job(vec_t v);
        int cnt = 0, idle_bad = 0, stab_bad = 0;
        logic [W-1:0] held;
        chk("idle_before_job", busy, 0);
        pulse_start(v.n[NT-1:0]);
        chk("busy_on_start", busy, 1);
        for (int t = 0; t < v.n; t++) begin
            if (t == 1 && v.gap > 0) begin
                for (int g = 0; g < v.gap; g++) begin
                    @(negedge clk);
                    if (!in_ready || p_shift_in || p_mac || p_shift_out || res_valid) idle_bad++;
                end
                chk("wait_in_accept", idle_bad, 0);
            end
            do_term(v.d[t], v.w[t], t == v.n - 1, v.poke && t == 0);
        end
        while (p_shift_out && cnt < 64) begin cnt++; @(negedge clk); end
        chk("drain_len", cnt, 32);
        chk("res_valid", res_valid, 1);
        chk("res_data", res_data, v.exp);
        chk("busy_in_done", busy, 1);
        held = res_data;
        for (int h = 0; h < v.hold; h++) begin
            @(negedge clk);
            if (!res_valid || res_data !== held || !busy) stab_bad++;
        end
        if (v.hold > 0) chk("backpressure_stable", stab_bad, 0);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("res_valid_drop", res_valid, 0);
        chk("busy_drop", busy, 0);
    endtask

    vec_t tbl[6];

    initial begin
        // Expected values are signed 32-bit sums of products, wrapped:
        //   3*4 + 5*6 + 7*(-2) = 28;  -5*7 = -35;  (-1)(-1) + 2^16*2^16 = 1 + 0;
        //   2*0x7fffffff + 1*2 = 2^32 -> 0
        tbl[0] = mk(1, 32'd1000, 32'd2000, '0, '0, '0, '0, 32'd2000000, 0, 0, 1'b0);
        tbl[1] = mk(3, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'hffff_fffe, 32'd28, 10, 0, 1'b0);
        tbl[2] = mk(1, 32'hffff_fffb, 32'd7, '0, '0, '0, '0, 32'hffff_ffdd, 0, 50, 1'b0);
        tbl[3] = mk(1, 32'd1, 32'd1, '0, '0, '0, '0, 32'd1, 0, 0, 1'b0);
        tbl[4] = mk(2, 32'hffff_ffff, 32'hffff_ffff, 32'h0001_0000, 32'h0001_0000, '0, '0,
                    32'd1, 0, 0, 1'b1);
        tbl[5] = mk(2, 32'h7fff_ffff, 32'd2, 32'd1, 32'd2, '0, '0, 32'd0, 0, 0, 1'b0);

        #12;
        chk("reset_outputs", {busy, in_ready, res_valid, res_data, p_shift_in, p_mac,
                              p_shift_out, p_data_in}, '0);
        @(negedge clk); nRst = 1'b1;
        @(negedge clk);

        // n_terms == 0 is not a job.
        pulse_start('0);
        chk("zero_terms_busy", busy, 0);
        chk("zero_terms_ready", in_ready, 0);

        for (int i = 0; i < 6; i++) run_job(tbl[i]);

        // Reset in the middle of SHIFT, then a fresh job.
        pulse_start(8'd1);
        in_data = 32'd9; in_weight = 32'd9; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (20) @(negedge clk);
        chk("shifting_before_reset", p_shift_in, 1);
        #2 nRst = 1'b0;
        #1 chk("async_reset_outputs", {busy, in_ready, res_valid, res_data, p_shift_in, p_mac,
                                       p_shift_out, p_data_in}, '0);
        @(negedge clk); nRst = 1'b1;
        @(negedge clk);
        run_job(mk(1, 32'd2, 32'd3, '0, '0, '0, '0, 32'd6, 0, 0, 1'b0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
